// File: rtl/gun_hit_if.sv
// Pin bundle between the light-gun front end and its hit detector.
// The master side drives the gun pins and video timing; the slave side drives the handshake and results.
interface gun_hit_if;
    logic       trigger_in;
    logic       light_in;
    logic       frame_start;
    logic       valid;
    logic [9:0] col;
    logic [9:0] row;
    logic       flash_req;
    logic       hit;
    logic       miss;
    logic       busy;
    logic [9:0] hit_col;
    logic [9:0] hit_row;

    modport master (
        output trigger_in, light_in, frame_start, valid, col, row,
        input  flash_req, hit, miss, busy, hit_col, hit_row
    );

    modport slave (
        input  trigger_in, light_in, frame_start, valid, col, row,
        output flash_req, hit, miss, busy, hit_col, hit_row
    );
endinterface

// File: rtl/gun_hit_detector.sv
// Light-gun flash-detect: debounces the trigger, requests a black then a white frame, and grades the shot.
// Optional macro HIT_POSITION_EN adds capture of the first white-frame light sample position.
module gun_hit_detector #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int BLACK_MAX       = 16,
    parameter int WHITE_MIN       = 64,
    parameter int CNT_W           = 16
) (
    input  logic      clk,
    input  logic      rst,
    gun_hit_if.slave  gi
);

    localparam int                DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_BLACK  = 3'd2,
        S_WHITE  = 3'd3,
        S_DECIDE = 3'd4,
        S_HOLD   = 3'd5
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    logic            trg_meta_r, trg_sync_r, lit_meta_r, lit_sync_r;
    logic            trg_db_r, trg_db_d_r;
    logic [DB_W-1:0] db_cnt_r;
    state_t          state_r, state_nx_s;
    logic [CNT_W-1:0] black_cnt_r, white_cnt_r;
    logic            flash_req_r, busy_r, hit_r, miss_r;
    logic            flash_nx_s, busy_nx_s, hit_nx_s, miss_nx_s;
    logic            trg_rise_s, pass_s;
    logic            count_black_s, count_white_s, black_entry_s, white_entry_s;

    // Two-flop synchronizers for the asynchronous gun pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trg_meta_r <= 1'b0;
            trg_sync_r <= 1'b0;
            lit_meta_r <= 1'b0;
            lit_sync_r <= 1'b0;
        end else begin
            trg_meta_r <= gi.trigger_in;
            trg_sync_r <= trg_meta_r;
            lit_meta_r <= gi.light_in;
            lit_sync_r <= lit_meta_r;
        end
    end

    // Trigger debounce: adopt the synced level after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt_r   <= {DB_W{1'b0}};
            trg_db_r   <= 1'b0;
            trg_db_d_r <= 1'b0;
        end else begin
            trg_db_d_r <= trg_db_r;
            if (trg_sync_r == trg_db_r) begin
                db_cnt_r <= {DB_W{1'b0}};
            end else if (db_cnt_r == DB_LAST) begin
                db_cnt_r <= {DB_W{1'b0}};
                trg_db_r <= trg_sync_r;
            end else begin
                db_cnt_r <= db_cnt_r + DB_W'(1);
            end
        end
    end

    assign trg_rise_s    = trg_db_r & ~trg_db_d_r;
    assign pass_s        = (32'(white_cnt_r) >= 32'(WHITE_MIN)) && (32'(black_cnt_r) <= 32'(BLACK_MAX));
    assign count_black_s = (state_r == S_BLACK) & ~gi.frame_start & gi.valid & lit_sync_r;
    assign count_white_s = (state_r == S_WHITE) & ~gi.frame_start & gi.valid & lit_sync_r;
    assign black_entry_s = (state_r == S_ARMED) & (state_nx_s == S_BLACK);
    assign white_entry_s = (state_r == S_BLACK) & (state_nx_s == S_WHITE);

    // Shot sequencer next-state and next-output decode
    always_comb begin
        state_nx_s = state_r;
        hit_nx_s   = 1'b0;
        miss_nx_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (trg_rise_s) begin
                    state_nx_s = S_ARMED;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_ARMED: begin
                if (!trg_db_r) begin
                    state_nx_s = S_IDLE;
                end else if (gi.frame_start) begin
                    state_nx_s = S_BLACK;
                end else begin
                    state_nx_s = S_ARMED;
                end
            end
            S_BLACK: begin
                if (gi.frame_start) begin
                    state_nx_s = S_WHITE;
                end else begin
                    state_nx_s = S_BLACK;
                end
            end
            S_WHITE: begin
                if (gi.frame_start) begin
                    state_nx_s = S_DECIDE;
                    hit_nx_s   = pass_s;
                    miss_nx_s  = ~pass_s;
                end else begin
                    state_nx_s = S_WHITE;
                end
            end
            S_DECIDE: begin
                state_nx_s = S_HOLD;
            end
            S_HOLD: begin
                if (!trg_db_r) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_HOLD;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase

        // flash_req stays up through the whole sequence; only HOLD follows the trigger
        flash_nx_s = 1'b0;
        busy_nx_s  = 1'b0;
        case (state_nx_s)
            S_ARMED, S_BLACK, S_WHITE, S_DECIDE: begin
                flash_nx_s = 1'b1;
                busy_nx_s  = 1'b1;
            end
            S_HOLD: begin
                flash_nx_s = trg_db_r;
                busy_nx_s  = 1'b0;
            end
            default: begin
                flash_nx_s = 1'b0;
                busy_nx_s  = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            flash_req_r <= 1'b0;
            busy_r      <= 1'b0;
            hit_r       <= 1'b0;
            miss_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            flash_req_r <= flash_nx_s;
            busy_r      <= busy_nx_s;
            hit_r       <= hit_nx_s;
            miss_r      <= miss_nx_s;
        end
    end

    // Saturating light-sample counters, cleared on entry to their frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            black_cnt_r <= {CNT_W{1'b0}};
            white_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (black_entry_s) begin
                black_cnt_r <= {CNT_W{1'b0}};
            end else if (count_black_s) begin
                black_cnt_r <= sat_inc(black_cnt_r);
            end else begin
                black_cnt_r <= black_cnt_r;
            end
            if (white_entry_s) begin
                white_cnt_r <= {CNT_W{1'b0}};
            end else if (count_white_s) begin
                white_cnt_r <= sat_inc(white_cnt_r);
            end else begin
                white_cnt_r <= white_cnt_r;
            end
        end
    end

`ifdef HIT_POSITION_EN
    logic [9:0] hit_col_r, hit_row_r;

    // First counted white sample is the one seen while the counter is still zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_col_r <= 10'd0;
            hit_row_r <= 10'd0;
        end else if (white_entry_s) begin
            hit_col_r <= 10'd0;
            hit_row_r <= 10'd0;
        end else if (count_white_s && (white_cnt_r == {CNT_W{1'b0}})) begin
            hit_col_r <= gi.col;
            hit_row_r <= gi.row;
        end else begin
            hit_col_r <= hit_col_r;
            hit_row_r <= hit_row_r;
        end
    end

    assign gi.hit_col = hit_col_r;
    assign gi.hit_row = hit_row_r;
`else
    assign gi.hit_col = 10'd0;
    assign gi.hit_row = 10'd0;
`endif

    assign gi.flash_req = flash_req_r;
    assign gi.busy      = busy_r;
    assign gi.hit       = hit_r;
    assign gi.miss      = miss_r;

endmodule

// File: tb/tb_gun_hit_detector.sv
// Directed bench for gun_hit_detector: a default instance plus a narrow-counter instance
// (CNT_W=4) sharing the same stimulus to show counter saturation through the hit/miss result.
module tb_gun_hit_detector;

    localparam int DBC = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_bad   = 0;
    int   hit_n   = 0;
    int   miss_n  = 0;
    logic flash_seen = 1'b0;
    logic both_seen  = 1'b0;

    always #5 clk = ~clk;

    gun_hit_if gi ();
    gun_hit_if gs ();

    assign gs.trigger_in  = gi.trigger_in;
    assign gs.light_in    = gi.light_in;
    assign gs.frame_start = gi.frame_start;
    assign gs.valid       = gi.valid;
    assign gs.col         = gi.col;
    assign gs.row         = gi.row;

    gun_hit_detector #(.DEBOUNCE_CYCLES(DBC)) u_dut (
        .clk (clk),
        .rst (rst),
        .gi  (gi)
    );

    gun_hit_detector #(.DEBOUNCE_CYCLES(DBC), .BLACK_MAX(14), .WHITE_MIN(15), .CNT_W(4)) u_sat (
        .clk (clk),
        .rst (rst),
        .gi  (gs)
    );

    // Pulse bookkeeping for the main instance
    always @(negedge clk) begin
        if (gi.hit)  hit_n  = hit_n + 1;
        if (gi.miss) miss_n = miss_n + 1;
        if (gi.flash_req) flash_seen = 1'b1;
        if (gi.hit && gi.miss) both_seen = 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fs_pulse();
        @(negedge clk);
        gi.frame_start = 1'b1;
        @(negedge clk);
        gi.frame_start = 1'b0;
    endtask

    task automatic body(input int n, input logic lit);
        gi.light_in = lit;
        idle(4);
        for (int i = 0; i < n; i++) begin
            gi.valid = 1'b1;
            gi.col   = 10'(300 + i);
            gi.row   = 10'd200;
            @(negedge clk);
        end
        gi.valid    = 1'b0;
        gi.light_in = 1'b0;
        idle(4);
    endtask

    task automatic press();
        gi.trigger_in = 1'b1;
        idle(DBC + 6);
    endtask

    task automatic release_trg();
        gi.trigger_in = 1'b0;
        idle(DBC + 6);
    endtask

    task automatic shot(input int nb, input logic lb, input int nw);
        fs_pulse();
        body(nb, lb);
        fs_pulse();
        body(nw, 1'b1);
        fs_pulse();
    endtask

    initial begin
        rst            = 1'b1;
        gi.trigger_in  = 1'b0;
        gi.light_in    = 1'b0;
        gi.frame_start = 1'b0;
        gi.valid       = 1'b0;
        gi.col         = 10'd0;
        gi.row         = 10'd0;
        idle(3);
        check_eq("rst_flash", gi.flash_req, 0);
        check_eq("rst_busy",  gi.busy,      0);
        check_eq("rst_hit",   gi.hit,       0);
        check_eq("rst_miss",  gi.miss,      0);
        rst = 1'b0;
        idle(3);

        // bounce: ten short presses never reach the debounce length
        flash_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            gi.trigger_in = 1'b1;
            idle(5);
            gi.trigger_in = 1'b0;
            idle(5);
        end
        idle(DBC + 6);
        check_eq("bounce_flash", gi.flash_req, 0);
        check_eq("bounce_seen",  flash_seen,   0);
        press();
        check_eq("press_flash", gi.flash_req, 1);
        check_eq("press_busy",  gi.busy,      1);

        // clean hit
        shot(20, 1'b0, 100);
        check_eq("hit_pulse",  gi.hit,  1);
        check_eq("hit_nomiss", gi.miss, 0);
        idle(1);
        check_eq("hit_single",     gi.hit,       0);
        check_eq("hit_hold_busy",  gi.busy,      0);
        check_eq("hit_hold_flash", gi.flash_req, 1);
`ifdef HIT_POSITION_EN
        check_eq("hit_col", gi.hit_col, 300);
        check_eq("hit_row", gi.hit_row, 200);
`else
        check_eq("hit_col", gi.hit_col, 0);
        check_eq("hit_row", gi.hit_row, 0);
`endif
        check_eq("hit_count1",  hit_n,  1);
        check_eq("miss_count0", miss_n, 0);
        release_trg();
        check_eq("rel_flash", gi.flash_req, 0);

        // cheat: 17 light samples in the black frame
        press();
        shot(17, 1'b1, 200);
        check_eq("cheat_miss",  gi.miss, 1);
        check_eq("cheat_nohit", gi.hit,  0);
        release_trg();
        check_eq("cheat_hits",   hit_n,  1);
        check_eq("cheat_misses", miss_n, 1);

        // abort in ARMED, then stray frame_starts
        press();
        check_eq("abort_busy_pre", gi.busy, 1);
        release_trg();
        check_eq("abort_flash", gi.flash_req, 0);
        check_eq("abort_busy",  gi.busy,      0);
        fs_pulse();
        fs_pulse();
        fs_pulse();
        idle(2);
        check_eq("abort_hits",   hit_n,  1);
        check_eq("abort_misses", miss_n, 1);

        // release in WHITE: sequence completes, flash drops after DECIDE
        press();
        fs_pulse();
        body(20, 1'b0);
        fs_pulse();
        body(100, 1'b1);
        gi.trigger_in = 1'b0;
        idle(DBC + 6);
        check_eq("relw_flash", gi.flash_req, 1);
        check_eq("relw_busy",  gi.busy,      1);
        fs_pulse();
        check_eq("relw_hit",   gi.hit,       1);
        check_eq("relw_flash_decide", gi.flash_req, 1);
        idle(1);
        check_eq("relw_flash_after", gi.flash_req, 0);
        check_eq("relw_busy_after",  gi.busy,      0);
        idle(4);

        // saturation via the 4-bit instance
        press();
        shot(20, 1'b0, 40);
        check_eq("sat_main_miss", gi.miss, 1);
        check_eq("sat_w_hit",     gs.hit,  1);
        check_eq("sat_w_nomiss",  gs.miss, 0);
        release_trg();
        press();
        shot(40, 1'b1, 40);
        check_eq("sat_b_miss",  gs.miss, 1);
        check_eq("sat_b_nohit", gs.hit,  0);
        release_trg();

        // reset mid-WHITE
        press();
        fs_pulse();
        body(10, 1'b1);
        fs_pulse();
        body(30, 1'b1);
        check_eq("mid_busy", gi.busy, 1);
        gi.trigger_in = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("mr_flash", gi.flash_req, 0);
        check_eq("mr_busy",  gi.busy,      0);
        check_eq("mr_hit",   gi.hit,       0);
        check_eq("mr_miss",  gi.miss,      0);
        check_eq("mr_bcnt",  32'(u_dut.black_cnt_r), 0);
        check_eq("mr_wcnt",  32'(u_dut.white_cnt_r), 0);
        check_eq("mr_state", 32'(u_dut.state_r),     0);
        idle(3);
        rst = 1'b0;
        idle(DBC + 6);
        check_eq("post_rst_flash", gi.flash_req, 0);
        check_eq("never_both", both_seen, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
